// File: rtl/seq_player.sv
// Plays the first round_len+1 colours of the sequence ROM on four LEDs with a dark gap between steps.
// Optional SEQ_PLAYER_ONEHOT_CHECK_EN adds a sticky err flag for non-one-hot ROM colours.
module seq_player #(
   parameter int ON_CYCLES  = 4,
   parameter int OFF_CYCLES = 2,
   parameter int ADDR_W     = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] round_len,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [3:0]        rom_data,
   output logic [3:0]        leds,
   output logic              busy,
   output logic              done,
`ifdef SEQ_PLAYER_ONEHOT_CHECK_EN
   output logic              err,
`endif
   output logic [1:0]        state_dbg
);

   localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SHOW = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t            state, state_n;
   logic [ADDR_W-1:0] addr_n;
   logic [ADDR_W-1:0] last_idx, last_n;
   logic [3:0]        leds_n;
   logic [TW-1:0]     timer, timer_n;
   logic              done_n;
   logic              bad_colour;

   assign bad_colour = (rom_data == 4'd0) || ((rom_data & (rom_data - 4'd1)) != 4'd0);

`ifdef SEQ_PLAYER_ONEHOT_CHECK_EN
   logic err_n;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         rom_addr <= '0;
         leds     <= 4'd0;
         timer    <= '0;
         last_idx <= '0;
         done     <= 1'b0;
`ifdef SEQ_PLAYER_ONEHOT_CHECK_EN
         err      <= 1'b0;
`endif
      end else begin
         state    <= state_n;
         rom_addr <= addr_n;
         leds     <= leds_n;
         timer    <= timer_n;
         last_idx <= last_n;
         done     <= done_n;
`ifdef SEQ_PLAYER_ONEHOT_CHECK_EN
         err      <= err_n;
`endif
      end
   end

   // Handshake: start is accepted only in a cycle where busy is low; done pulses once per completed playback.
   always_comb begin
      state_n = state;
      addr_n  = rom_addr;
      leds_n  = leds;
      timer_n = timer;
      last_n  = last_idx;
      done_n  = 1'b0;
`ifdef SEQ_PLAYER_ONEHOT_CHECK_EN
      err_n   = err;
`endif
      unique case (state)
         IDLE: begin
            addr_n  = '0;
            leds_n  = 4'd0;
            timer_n = '0;
            if (start) begin
               state_n = SHOW;
               last_n  = round_len;
               leds_n  = rom_data;
`ifdef SEQ_PLAYER_ONEHOT_CHECK_EN
               err_n   = bad_colour;
`endif
            end
         end
         SHOW: begin
            if (abort) begin
               state_n = IDLE;
               leds_n  = 4'd0;
               addr_n  = '0;
               timer_n = '0;
            end else if (timer == TW'(ON_CYCLES - 1)) begin
               leds_n  = 4'd0;
               timer_n = '0;
               if (rom_addr == last_idx) begin
                  state_n = IDLE;
                  addr_n  = '0;
                  done_n  = 1'b1;
               end else begin
                  state_n = GAP;
                  addr_n  = rom_addr + ADDR_W'(1);
               end
            end else begin
               timer_n = timer + TW'(1);
            end
         end
         GAP: begin
            // The address was advanced on entry, so rom_data already holds the next colour.
            if (abort) begin
               state_n = IDLE;
               leds_n  = 4'd0;
               addr_n  = '0;
               timer_n = '0;
            end else if (timer == TW'(OFF_CYCLES - 1)) begin
               state_n = SHOW;
               leds_n  = rom_data;
               timer_n = '0;
`ifdef SEQ_PLAYER_ONEHOT_CHECK_EN
               err_n   = err | bad_colour;
`endif
            end else begin
               timer_n = timer + TW'(1);
            end
         end
         default: begin
            state_n = IDLE;
            addr_n  = '0;
            leds_n  = 4'd0;
            timer_n = '0;
         end
      endcase
   end

   assign busy      = (state != IDLE);
   assign state_dbg = state;

`ifndef SEQ_PLAYER_ONEHOT_CHECK_EN
   logic unused_ok;
   assign unused_ok = bad_colour;
`endif

endmodule
